// File: rtl/dual_port_bus_arbiter_if.sv
// Valid/ready request bus between one requester and one responder.
// The requester drives the request fields; the responder returns ready/rdata.
interface dual_port_bus_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/dual_port_bus_arbiter.sv
// Round-robin arbiter sharing one slave port between two masters.
// One transaction at a time; optional timeout completes a stalled access with err.
module dual_port_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           resetn,
  dual_port_bus_arbiter_if.slave         m0,
  dual_port_bus_arbiter_if.slave         m1,
  dual_port_bus_arbiter_if.master        s,
  output logic                           grant,
  output logic                           err
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CMP_W  = CNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic             TO_EN  = (TIMEOUT != 0);
  localparam logic [CMP_W-1:0] TO_LIM = CMP_W'(TIMEOUT);

  logic [1:0]        state_q,    state_d;
  logic              s_valid_q,  s_valid_d;
  logic [ADDR_W-1:0] s_addr_q,   s_addr_d;
  logic [DATA_W-1:0] s_wdata_q,  s_wdata_d;
  logic [STRB_W-1:0] s_wstrb_q,  s_wstrb_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              err_q,      err_d;
  logic              grant_q,    grant_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              pick_m1_c;
  logic              fin_c;
  logic              fin_err_c;
  logic [DATA_W-1:0] fin_data_c;

  // Next-state and output logic; completion is resolved once after the case.
  always_comb begin
    state_d    = state_q;
    s_valid_d  = s_valid_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    err_d      = 1'b0;
    pick_m1_c  = 1'b0;
    fin_c      = 1'b0;
    fin_err_c  = 1'b0;
    fin_data_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (m0.valid || m1.valid) begin
          // Tie goes to the master not granted last; a lone requester always wins.
          pick_m1_c = (m0.valid && m1.valid) ? ~grant_q : m1.valid;
          grant_d   = pick_m1_c;
          s_addr_d  = pick_m1_c ? m1.addr  : m0.addr;
          s_wdata_d = pick_m1_c ? m1.wdata : m0.wdata;
          s_wstrb_d = pick_m1_c ? m1.wstrb : m0.wstrb;
          s_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s.ready) begin
          fin_c      = 1'b1;
          fin_data_c = s.rdata;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // A slave ready in the firing cycle takes the branch above instead.
          if (TO_EN && ((CMP_W'(cnt_q) + CMP_W'(1)) == TO_LIM)) begin
            fin_c      = 1'b1;
            fin_err_c  = 1'b1;
            fin_data_c = '1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fin_c) begin
      state_d   = ST_DONE;
      s_valid_d = 1'b0;
      err_d     = fin_err_c;
      if (grant_q) begin
        m1_ready_d = 1'b1;
        m1_rdata_d = fin_data_c;
      end else begin
        m0_ready_d = 1'b1;
        m0_rdata_d = fin_data_c;
      end
    end
  end

  // State registers; grant resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      s_valid_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      err_q      <= 1'b0;
      grant_q    <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
    end
  end

  assign s.valid  = s_valid_q;
  assign s.addr   = s_addr_q;
  assign s.wdata  = s_wdata_q;
  assign s.wstrb  = s_wstrb_q;
  assign m0.ready = m0_ready_q;
  assign m1.ready = m1_ready_q;
  assign m0.rdata = m0_rdata_q;
  assign m1.rdata = m1_rdata_q;
  assign grant    = grant_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dual_port_bus_arbiter.sv
// Bench for dual_port_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model of the shared port.
module tb_dual_port_bus_arbiter;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic resetn;
  logic grant;
  logic err;

  dual_port_bus_arbiter_if m0_if ();
  dual_port_bus_arbiter_if m1_if ();
  dual_port_bus_arbiter_if s_if ();

  dual_port_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .resetn(resetn),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .grant (grant),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Request fields currently presented by each master.
  logic [31:0] ia [2];
  logic [31:0] iw [2];
  logic [3:0]  is [2];

  // Reference model: who owns the slave port, what it should show, what each master got.
  int          md_owner;
  int          md_last;
  int          md_stall;
  bit          md_holdoff;
  bit          md_sv;
  logic [31:0] md_saddr;
  logic [31:0] md_swdata;
  logic [3:0]  md_swstrb;
  bit          md_ready [2];
  logic [31:0] md_rdata [2];
  bit          md_err;

  task automatic drive_fields();
    m0_if.addr = ia[0]; m0_if.wdata = iw[0]; m0_if.wstrb = is[0];
    m1_if.addr = ia[1]; m1_if.wdata = iw[1]; m1_if.wstrb = is[1];
  endtask

  // Drive one cycle of inputs, then land on the next falling edge.
  task automatic tick(input bit v0, input bit v1, input bit sr, input logic [31:0] srd);
    m0_if.valid = v0; m1_if.valid = v1; s_if.ready = sr; s_if.rdata = srd;
    drive_fields();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 0, 32'h0);
    resetn = 1'b1;
    tick(0, 0, 0, 32'h0);
  endtask

  task automatic model_reset();
    md_owner = -1; md_last = 1; md_stall = 0; md_holdoff = 0; md_sv = 0;
    md_saddr = '0; md_swdata = '0; md_swstrb = '0; md_err = 0;
    md_ready[0] = 0; md_ready[1] = 0; md_rdata[0] = '0; md_rdata[1] = '0;
  endtask

  task automatic model_finish(input logic [31:0] data, input bit e);
    md_ready[md_owner] = 1; md_rdata[md_owner] = data; md_err = e;
    md_sv = 0; md_owner = -1; md_holdoff = 1;
  endtask

  // Predict the outputs after the coming edge from the inputs of this cycle.
  task automatic model_step(input bit v0, input bit v1, input bit sr, input logic [31:0] srd);
    int w;
    md_ready[0] = 0; md_ready[1] = 0; md_err = 0;
    if (md_holdoff) begin
      md_holdoff = 0;
    end else if (md_owner < 0) begin
      if (v0 || v1) begin
        w = (v0 && v1) ? 1 - md_last : (v0 ? 0 : 1);
        md_owner = w; md_last = w; md_stall = 0; md_sv = 1;
        md_saddr = ia[w]; md_swdata = iw[w]; md_swstrb = is[w];
      end
    end else if (sr) begin
      model_finish(srd, 0);
    end else begin
      md_stall++;
      if (TO != 0 && md_stall == int'(TO)) model_finish(32'hFFFF_FFFF, 1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ia[0] = $urandom; iw[0] = $urandom; is[0] = 4'hF;
    ia[1] = $urandom; iw[1] = $urandom; is[1] = 4'h3;
    tick(1, 1, 1, $urandom);
    tick(1, 1, 1, $urandom);
    n_tests++; if (s_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_svalid: got %b want 0", s_if.valid); end
    n_tests++; if (s_if.addr !== 32'h0) begin n_fail++; $display("FAIL reset_saddr: got %h want 0", s_if.addr); end
    n_tests++; if (s_if.wdata !== 32'h0) begin n_fail++; $display("FAIL reset_swdata: got %h want 0", s_if.wdata); end
    n_tests++; if (s_if.wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_swstrb: got %h want 0", s_if.wstrb); end
    n_tests++; if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", m1_if.ready, m0_if.ready); end
    n_tests++; if (m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_if.rdata, m1_if.rdata); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (grant !== 1'b1) begin n_fail++; $display("FAIL reset_grant: got %b want 1", grant); end
    resetn = 1'b1;
    tick(0, 0, 0, 32'h0);
  endtask

  task automatic test_single_read();
    ia[0] = 32'h10; iw[0] = 32'h0; is[0] = 4'h0;
    tick(1, 0, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b1) begin n_fail++; $display("FAIL read_svalid: got %b want 1", s_if.valid); end
    n_tests++; if (s_if.addr !== 32'h10 || s_if.wstrb !== 4'h0) begin n_fail++; $display("FAIL read_sreq: got %h/%h want 10/0", s_if.addr, s_if.wstrb); end
    n_tests++; if (grant !== 1'b0) begin n_fail++; $display("FAIL read_grant: got %b want 0", grant); end
    tick(1, 0, 1, 32'hDEAD_BEEF);
    n_tests++; if (m0_if.ready !== 1'b1 || m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL read_ready: got m0=%b m1=%b want 1/0", m0_if.ready, m1_if.ready); end
    n_tests++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata: got %h want deadbeef", m0_if.rdata); end
    n_tests++; if (m1_if.rdata !== 32'h0 || err !== 1'b0 || s_if.valid !== 1'b0) begin n_fail++; $display("FAIL read_side: got m1rd=%h err=%b sv=%b want 0/0/0", m1_if.rdata, err, s_if.valid); end
    tick(1, 0, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b0 || m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL read_done_stale: got sv=%b rdy=%b want 0/0", s_if.valid, m0_if.ready); end
    tick(0, 0, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b0) begin n_fail++; $display("FAIL read_idle: got %b want 0", s_if.valid); end
  endtask

  task automatic test_round_robin();
    int p0, p1, g;
    p0 = 0; p1 = 0;
    do_reset();
    ia[0] = 32'h100; iw[0] = 32'hA0; is[0] = 4'h0;
    ia[1] = 32'h200; iw[1] = 32'hB0; is[1] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      tick(1, 1, 0, 32'h0);
      n_tests++; if (s_if.valid !== 1'b1 || grant !== 1'(g)) begin n_fail++; $display("FAIL rr_grant%0d: got sv=%b g=%b want 1/%0d", k, s_if.valid, grant, g); end
      n_tests++; if (s_if.addr !== ia[g]) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, s_if.addr, ia[g]); end
      tick(1, 1, 1, 32'h5000_0000 + 32'(k));
      p0 += int'(m0_if.ready); p1 += int'(m1_if.ready);
      n_tests++; if ((g == 0 ? m0_if.rdata : m1_if.rdata) !== 32'h5000_0000 + 32'(k)) begin n_fail++; $display("FAIL rr_rdata%0d: got %h/%h", k, m0_if.rdata, m1_if.rdata); end
      tick(1, 1, 0, 32'h0);
      p0 += int'(m0_if.ready); p1 += int'(m1_if.ready);
      n_tests++; if (s_if.valid !== 1'b0) begin n_fail++; $display("FAIL rr_done%0d: got sv=%b want 0", k, s_if.valid); end
    end
    n_tests++; if (p0 != 2 || p1 != 2) begin n_fail++; $display("FAIL rr_pulses: got m0=%0d m1=%0d want 2/2", p0, p1); end
    tick(0, 0, 0, 32'h0);
  endtask

  task automatic test_write();
    ia[1] = 32'h1000_0000; iw[1] = 32'h1234_5678; is[1] = 4'b0011;
    tick(0, 1, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b1 || grant !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got sv=%b g=%b want 1/1", s_if.valid, grant); end
    n_tests++; if (s_if.addr !== 32'h1000_0000 || s_if.wdata !== 32'h1234_5678 || s_if.wstrb !== 4'b0011) begin n_fail++; $display("FAIL wr_req1: got %h/%h/%h", s_if.addr, s_if.wdata, s_if.wstrb); end
    ia[1] = $urandom; iw[1] = $urandom; is[1] = 4'hC;
    tick(0, 1, 0, 32'h0);
    n_tests++; if (s_if.addr !== 32'h1000_0000 || s_if.wdata !== 32'h1234_5678 || s_if.wstrb !== 4'b0011) begin n_fail++; $display("FAIL wr_req2: got %h/%h/%h", s_if.addr, s_if.wdata, s_if.wstrb); end
    n_tests++; if (m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL wr_early: got %b want 0", m1_if.ready); end
    tick(0, 1, 1, 32'h0BAD_0BAD);
    n_tests++; if (m1_if.ready !== 1'b1 || m0_if.ready !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL wr_ready: got m1=%b m0=%b err=%b want 1/0/0", m1_if.ready, m0_if.ready, err); end
    n_tests++; if (m1_if.rdata !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL wr_rdata: got %h want 0bad0bad", m1_if.rdata); end
    tick(0, 0, 0, 32'h0);
    n_tests++; if (m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL wr_once: got %b want 0", m1_if.ready); end
  endtask

  task automatic test_timeout();
    ia[0] = 32'h20; iw[0] = 32'h0; is[0] = 4'h0;
    tick(1, 0, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b1 || grant !== 1'b0) begin n_fail++; $display("FAIL to_grant: got sv=%b g=%b want 1/0", s_if.valid, grant); end
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 0, $urandom);
      if (i < 4) begin
        n_tests++; if (m0_if.ready !== 1'b0 || err !== 1'b0 || s_if.valid !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d: got rdy=%b err=%b sv=%b want 0/0/1", i, m0_if.ready, err, s_if.valid); end
      end else begin
        n_tests++; if (m0_if.ready !== 1'b1 || err !== 1'b1 || s_if.valid !== 1'b0) begin n_fail++; $display("FAIL to_fire: got rdy=%b err=%b sv=%b want 1/1/0", m0_if.ready, err, s_if.valid); end
        n_tests++; if (m0_if.rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_rdata: got %h want ffffffff", m0_if.rdata); end
        n_tests++; if (m1_if.ready !== 1'b0 || m1_if.rdata !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL to_other: got rdy=%b rd=%h want 0/0bad0bad", m1_if.ready, m1_if.rdata); end
      end
    end
    tick(0, 0, 0, 32'h0);
    n_tests++; if (err !== 1'b0 || m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got err=%b rdy=%b want 0/0", err, m0_if.ready); end
  endtask

  task automatic test_race();
    ia[0] = 32'h30; iw[0] = 32'h0; is[0] = 4'h0;
    tick(1, 0, 0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0, 0, 32'h0);
      n_tests++; if (m0_if.ready !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL race_wait%0d: got rdy=%b err=%b want 0/0", i, m0_if.ready, err); end
    end
    tick(1, 0, 1, 32'hCAFE_0001);
    n_tests++; if (m0_if.ready !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL race_done: got rdy=%b err=%b want 1/0", m0_if.ready, err); end
    n_tests++; if (m0_if.rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL race_rdata: got %h want cafe0001", m0_if.rdata); end
    tick(0, 0, 0, 32'h0);
  endtask

  task automatic test_reset_busy();
    ia[0] = 32'h40; iw[0] = 32'h0; is[0] = 4'h0;
    ia[1] = 32'h44; iw[1] = 32'h0; is[1] = 4'h0;
    tick(1, 0, 0, 32'h0);
    tick(1, 0, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b1 || grant !== 1'b0) begin n_fail++; $display("FAIL rb_busy: got sv=%b g=%b want 1/0", s_if.valid, grant); end
    resetn = 1'b0;
    tick(1, 1, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b0 || grant !== 1'b1) begin n_fail++; $display("FAIL rb_abandon: got sv=%b g=%b want 0/1", s_if.valid, grant); end
    tick(1, 1, 1, 32'h1111_2222);
    n_tests++; if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rb_noready: got %b%b err=%b want 00/0", m1_if.ready, m0_if.ready, err); end
    resetn = 1'b1;
    tick(1, 1, 0, 32'h0);
    n_tests++; if (s_if.valid !== 1'b1 || grant !== 1'b0 || s_if.addr !== 32'h40) begin n_fail++; $display("FAIL rb_tie: got sv=%b g=%b a=%h want 1/0/40", s_if.valid, grant, s_if.addr); end
    tick(1, 1, 1, 32'h3333_4444);
    n_tests++; if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL rb_after: got rdy=%b rd=%h want 1/33334444", m0_if.ready, m0_if.rdata); end
    tick(0, 0, 0, 32'h0);
  endtask

  task automatic test_random();
    bit          pend [2];
    bit          sr;
    logic [31:0] srd;
    int          sl_cnt, sl_lat;
    pend[0] = 0; pend[1] = 0; sl_cnt = 0; sl_lat = 0;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(3) != 0) begin
          pend[m] = 1; ia[m] = $urandom; iw[m] = $urandom;
          is[m] = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
        end
      end
      if (md_sv && $urandom_range(3) == 0) begin
        ia[md_owner] = $urandom; iw[md_owner] = $urandom; is[md_owner] = 4'($urandom);
      end
      if (md_sv) begin
        if (sl_cnt == 0) sl_lat = int'($urandom_range(5));
        sr = (sl_cnt == sl_lat);
        sl_cnt++;
      end else begin
        sl_cnt = 0;
        sr = 1'($urandom_range(1));
      end
      srd = $urandom;
      model_step(pend[0], pend[1], sr, srd);
      tick(pend[0], pend[1], sr, srd);
      n_tests++; if (s_if.valid !== md_sv) begin n_fail++; $display("FAIL rnd_svalid c%0d: got %b want %b", c, s_if.valid, md_sv); end
      n_tests++; if (grant !== 1'(md_last)) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %0d", c, grant, md_last); end
      n_tests++; if (m0_if.ready !== md_ready[0] || m1_if.ready !== md_ready[1]) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, m1_if.ready, m0_if.ready, md_ready[1], md_ready[0]); end
      n_tests++; if (err !== md_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, err, md_err); end
      n_tests++; if (m0_if.rdata !== md_rdata[0] || m1_if.rdata !== md_rdata[1]) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h/%h", c, m0_if.rdata, m1_if.rdata, md_rdata[0], md_rdata[1]); end
      n_tests++; if (m0_if.ready === 1'b1 && m1_if.ready === 1'b1) begin n_fail++; $display("FAIL rnd_onehot c%0d: got both ready want at most one", c); end
      if (md_sv) begin
        n_tests++; if (s_if.addr !== md_saddr || s_if.wdata !== md_swdata || s_if.wstrb !== md_swstrb) begin n_fail++; $display("FAIL rnd_sreq c%0d: got %h/%h/%h want %h/%h/%h", c, s_if.addr, s_if.wdata, s_if.wstrb, md_saddr, md_swdata, md_swstrb); end
      end
      for (int m = 0; m < 2; m++) if (md_ready[m]) pend[m] = 0;
    end
  endtask

  initial begin
    resetn = 1'b0;
    m0_if.valid = 1'b0; m1_if.valid = 1'b0; s_if.ready = 1'b0; s_if.rdata = '0;
    for (int m = 0; m < 2; m++) begin ia[m] = '0; iw[m] = '0; is[m] = '0; end
    drive_fields();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_race();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dual_port_bus_arbiter.md
DUAL_PORT_BUS_ARBITER -- requirements
Module: dual_port_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the number of cycles to wait for s_ready before error completion; 0 disables the timeout.
REQ-002 The reset is resetn, synchronous, active-low; the clock is clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 m0_valid/m1_valid  in  1  master request, held until that master's ready.
REQ-006 m0_addr/m1_addr  in  32  byte address.
REQ-007 m0_wdata/m1_wdata  in  32  write data.
REQ-008 m0_wstrb/m1_wstrb  in  4  byte strobes; 0 means read.
REQ-009 m0_ready/m1_ready  out  1  one-cycle completion pulse.
REQ-010 m0_rdata/m1_rdata  out  32  read data, valid with ready.
REQ-011 s_valid  out  1  shared-port request.
REQ-012 s_addr, s_wdata, s_wstrb  out  32/32/4  shared-port request fields.
REQ-013 s_ready  in  1  slave completion, sampled only while s_valid=1.
REQ-014 s_rdata  in  32  slave read data, valid with s_ready.
REQ-015 grant  out  1  index of the current or last granted master.
REQ-016 err  out  1  one-cycle pulse on a timeout completion.

Function
REQ-017 The arbiter SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-018 In IDLE with any mN_valid=1, the arbiter SHALL grant one master, latch its addr/wdata/wstrb into s_*, set s_valid=1 and go to BUSY on the next edge.
REQ-019 When both masters request in the same IDLE cycle, the arbiter SHALL grant the master not granted last (round-robin); a single requester SHALL be granted regardless of history.
REQ-020 s_addr/s_wdata/s_wstrb SHALL remain stable while s_valid=1, even if master inputs change.
REQ-021 In BUSY with s_ready=1, the arbiter SHALL drive mG_ready=1 and mG_rdata=s_rdata on the next cycle, drop s_valid, and go to DONE.
REQ-022 In BUSY, the arbiter SHALL count cycles with s_ready=0. When TIMEOUT is nonzero and the count reaches TIMEOUT, it SHALL complete with mG_rdata=32'hFFFF_FFFF, err=1 and mG_ready=1 for one cycle, then go to DONE.
REQ-023 s_ready arriving in the same cycle the timeout fires SHALL win: normal completion, err=0.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE, so that a master's stale valid is not re-granted; no new grant SHALL be made in DONE.
REQ-025 The non-granted master's ready SHALL stay 0 and its rdata SHALL hold its last value.
REQ-026 Minimum turnaround SHALL be: request in IDLE at T, s_valid=1 at T+1, s_ready at T+1 gives mG_ready at T+2, DONE at T+2, IDLE at T+3.
REQ-027 At most one of m0_ready/m1_ready SHALL be 1 in any cycle, and ready SHALL never be asserted to a master whose valid was 0 at grant time.
REQ-028 s_ready while s_valid=0 SHALL be ignored.
REQ-029 The timeout counter SHALL be 8 bits wide and SHALL clear on every grant.

Reset
REQ-030 While resetn=0, the block SHALL force: state=IDLE, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, m0_ready=0, m1_ready=0, m0_rdata=0, m1_rdata=0, err=0, grant=1 (so that m0 wins the first tie), and timeout counter=0.
REQ-031 Reset asserted mid-transaction SHALL abandon that transaction without a ready pulse, and s_valid SHALL be 0 on the edge after resetn is sampled low.

Verification
REQ-032 Single read: m0 read at addr 0x10 with the slave returning 0xDEADBEEF in the first BUSY cycle -> m0_ready pulse at T+2 with m0_rdata=0xDEADBEEF, and m1 stays idle.
REQ-033 Simultaneous: m0 and m1 both request continuously after reset -> grant sequence 0,1,0,1, each transaction 3 cycles with a zero-wait slave, no lost or duplicated ready pulses.
REQ-034 Write: m1 writes wdata=0x12345678 with wstrb=4'b0011 to 0x1000_0000 -> s_* match these values throughout BUSY, and m1_ready pulses once.
REQ-035 Timeout: TIMEOUT=4 with the slave never asserting ready -> err and m0_ready pulse together after 4 BUSY cycles, with m0_rdata=0xFFFF_FFFF.
REQ-036 Race: TIMEOUT=4 with s_ready on the 4th BUSY cycle -> normal completion, err=0.
REQ-037 Reset during BUSY with a stalled slave -> s_valid=0 on the next edge, no ready pulse, and after release m0 wins the first tie.
